// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: architectural PC, single-outstanding imem requests and an in-order
// instruction FIFO toward decode. Define FETCH_PERF_EN to add the saturating stall counter port.
module pc_fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]      stall_cnt_o,
`endif
    input  logic             instr_ready_i
);

    localparam int unsigned      PTR_W      = $clog2(QDEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   fetch_pc_q;
    logic [WIDTH-1:0]   req_pc_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   mem_instr_q [QDEPTH];
    logic [WIDTH-1:0]   mem_pc_q    [QDEPTH];
    logic [WIDTH-1:0]   last_instr_q;
    logic [WIDTH-1:0]   last_pc_q;

    logic handshake;
    logic push;
    logic pop;
    logic busy_next;

    assign imem_req_o    = (state_q == StReq) && (count_q < CNT_W'(QDEPTH));
    assign imem_addr_o   = fetch_pc_q;
    assign handshake     = imem_req_o && imem_gnt_i;
    assign instr_valid_o = (count_q != '0);
    assign push          = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;

    // A transaction is still in flight after this edge unless its response lands now.
    assign busy_next = (((state_q == StWait) || (state_q == StDrain)) && !imem_rvalid_i)
                       || handshake;

    // Empty FIFO shows the last popped word rather than a stale storage slot.
    assign instr_o    = instr_valid_o ? mem_instr_q[rd_ptr_q] : last_instr_q;
    assign instr_pc_o = instr_valid_o ? mem_pc_q[rd_ptr_q]    : last_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else if (redirect_i) begin
            fetch_pc_q <= redirect_target_i & ALIGN_MASK;
            state_q    <= busy_next ? StDrain : StReq;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (handshake) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + WIDTH'(4);
                        state_q    <= StWait;
                    end
                end
                StWait:  if (imem_rvalid_i) state_q <= StReq;
                StDrain: if (imem_rvalid_i) state_q <= StReq;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else if (redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                last_instr_q <= mem_instr_q[rd_ptr_q];
                last_pc_q    <= mem_pc_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata_i;
            mem_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!instr_valid_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
